uart_rx_controller: RTL and testbench
=====================================

# uart_rx_controller

Receive-side sequencer for the UART RX path of the pipelined LSU. Synchronises the serial line, detects and qualifies the start bit, times mid-bit sampling at a parameterised baud divisor, and assembles a 10-bit frame. It strobes the frame into the RX data register (`get_o`/`frame_o`) and presents the payload byte to the LSU over a valid/ready handshake, flagging framing errors and overruns.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per bit. Must be even and ≥ 4; counter width is `$clog2(CLKS_PER_BIT)`.

Ports:
- `clk`  input  1: single clock; all state on rising edge.
- `reset`  input  1: asynchronous, active-low reset (`reset`=0 resets).
- `rx_i`  input  1: serial line, idle high, asynchronous to `clk`.
- `rx_ready_i`  input  1: consumer ready for `rx_data_o`.
- `rx_data_o`  output  8: received byte.
- `rx_valid_o`  output  1: `rx_data_o` holds an unconsumed byte.
- `frame_o`  output  10: assembled frame; [0] start bit, [8:1] data LSB-first, [9] stop bit.
- `get_o`  output  1: one-cycle load strobe for the RX data register.
- `frame_err_o`  output  1: one-cycle pulse, stop bit sampled 0.
- `overrun_o`  output  1: one-cycle pulse, good frame dropped because the previous byte was unconsumed.

## Operation
- 2-FF synchroniser on `rx_i` gives `rx_s`. Both flops reset to 1 (line idle).
- FSM states: IDLE, START, DATA, STOP. Internal signals: bit counter `cnt`, bit index `idx` (0..7), and shift register.
- IDLE: if `rx_s`=0, go to START with `cnt`=0. Otherwise stay.
- START: increment `cnt`. At `cnt`=CLKS_PER_BIT/2−1:
  - if `rx_s`=0, go to DATA with `cnt`=0 and `idx`=0;
  - else treat as a glitch and return to IDLE with no outputs.
- DATA: increment `cnt`. At `cnt`=CLKS_PER_BIT−1:
  - sample `rx_s` into data bit `idx` (LSB first) and set `cnt`=0;
  - if `idx`=7, go to STOP; else `idx`+1.
- STOP: at `cnt`=CLKS_PER_BIT−1, sample the stop bit, then return to IDLE. On that edge:
  - `frame_o` <= {stop, data, 1'b0}; `get_o`=1 for one cycle (always, good or bad frame).
  - If stop=0: `frame_err_o` pulses. `rx_data_o`/`rx_valid_o` unchanged.
  - If stop=1 and slot free: `rx_data_o` <= data and `rx_valid_o` <= 1. The slot is free when `rx_valid_o`=0, or when `rx_valid_o`=1 and `rx_ready_i`=1 this cycle.
  - If stop=1 and slot not free: byte dropped, `overrun_o` pulses, `rx_data_o` keeps the old byte.
- Handshake:
  - Transfer occurs on any edge with `rx_valid_o`=1 and `rx_ready_i`=1. `rx_valid_o` clears next edge unless a new byte loads on the same edge.
  - `rx_data_o` is stable while `rx_valid_o`=1.
- Ready is ignored while `rx_valid_o`=0.

## Timing
- Reset values: FSM=IDLE, `cnt`=0, `idx`=0, sync flops=1, `rx_data_o`=0, `frame_o`=0, `rx_valid_o`=0, `get_o`=0, `frame_err_o`=0, `overrun_o`=0.
- Reset asserted mid-frame: immediate return to IDLE and all outputs cleared. After release, no frame is reported until a new start edge.
- Let edge E0 be the first edge that samples `rx_i` low. Then:
  - `rx_s` falls at E0+1;
  - START is entered at E0+2;
  - `rx_valid_o`, `get_o` and `frame_o` update at E0+2+CLKS_PER_BIT/2+9·CLKS_PER_BIT.
- Sampling points: mid-bit (CLKS_PER_BIT/2 after the detected start edge, then every CLKS_PER_BIT).
- A new start bit is accepted from the cycle after STOP completes (back-to-back frames supported, no idle bit required).
- Pulse outputs are exactly one cycle wide.

## Test plan
All tests use CLKS_PER_BIT=16.
- Frame 0xA5, good stop, `rx_ready_i`=0 -> at E0+154: `rx_data_o`=0xA5, `rx_valid_o`=1, `get_o` pulses, `frame_o`=10'b1_1010_0101_0. Then raise `rx_ready_i` -> `rx_valid_o`=0 on the following edge.
- 4-cycle low glitch on `rx_i` -> FSM returns to IDLE. No `get_o`, no valid, no error.
- Frame 0x3C with stop bit 0 -> `frame_err_o` and `get_o` pulse once, `frame_o`[9]=0, `rx_valid_o` stays 0.
- Send 0x11 then 0x22 back-to-back with `rx_ready_i`=0 -> `overrun_o` pulses at the end of frame 2, `rx_data_o` stays 0x11.
- Repeat with `rx_ready_i`=1 held only on the frame-2 completion edge -> 0x11 consumed and 0x22 loaded on the same edge, `rx_valid_o` stays 1, no overrun.
- Assert `reset`=0 during data bit 4 of frame 0xFF -> all outputs 0 immediately. After release, send 0x5A -> `rx_data_o`=0x5A received correctly.

Source files
------------

// File: rtl/uart_rx_controller.sv
`default_nettype none
// uart_rx_controller: UART receive sequencer. Synchronises rx_i, samples mid-bit,
// assembles a 10-bit frame and hands the payload byte out over valid/ready.
module uart_rx_controller #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_i,
  input  logic       rx_ready_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic [9:0] frame_o,
  output logic       get_o,
  output logic       frame_err_o,
  output logic       overrun_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shift;
  logic             sync1;
  logic             rx_s;
  logic             slot_free;

  // A byte may be loaded into the output slot when it is empty or is being consumed now.
  assign slot_free = !rx_valid_o || rx_ready_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx_i;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= 3'd0;
      shift       <= 8'd0;
      rx_data_o   <= 8'd0;
      rx_valid_o  <= 1'b0;
      frame_o     <= 10'd0;
      get_o       <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      get_o       <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;

      if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end

        START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            idx   <= 3'd0;
            // A line that is high again at mid start bit was only a glitch.
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt        <= '0;
            shift[idx] <= rx_s;
            if (idx == 3'd7) begin
              state <= STOP;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            state   <= IDLE;
            frame_o <= {rx_s, shift, 1'b0};
            get_o   <= 1'b1;
            if (!rx_s) begin
              frame_err_o <= 1'b1;
            end else if (slot_free) begin
              rx_data_o  <= shift;
              rx_valid_o <= 1'b1;
            end else begin
              overrun_o <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_controller.sv
`default_nettype none
// Self-checking bench for uart_rx_controller at CLKS_PER_BIT=16: directed vector
// table, hand-written corner sequences and random traffic against a frame-level model.
module tb_uart_rx_controller;

  localparam int CPB = 16;
  localparam int LAT = 2 + CPB / 2 + 9 * CPB;  // first low sample to frame completion
  localparam int NV  = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_i = 1'b1;
  logic       rx_ready_i = 1'b0;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic [9:0] frame_o;
  logic       get_o;
  logic       frame_err_o;
  logic       overrun_o;

  uart_rx_controller #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_i       (rx_i),
    .rx_ready_i (rx_ready_i),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .frame_o    (frame_o),
    .get_o      (get_o),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, want, cyc);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] e_data, input logic e_valid,
                           input logic [9:0] e_frame, input logic e_get, input logic e_ferr,
                           input logic e_ovr);
    check({tag, ".data"},  rx_data_o,   e_data);
    check({tag, ".valid"}, rx_valid_o,  e_valid);
    check({tag, ".frame"}, frame_o,     e_frame);
    check({tag, ".get"},   get_o,       e_get);
    check({tag, ".ferr"},  frame_err_o, e_ferr);
    check({tag, ".ovr"},   overrun_o,   e_ovr);
  endtask

  // Wait (at falling edges) until rising edge number 'target' has happened.
  task automatic wait_edge(input int target);
    while (cyc < target) @(negedge clk);
    if (cyc != target) begin
      n_err++;
      $display("FAIL wait_edge: reached edge %0d expected %0d", cyc, target);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  typedef struct {
    int         done;
    logic [7:0] data;
    logic       stop;
  } pend_t;

  pend_t      pend[$];
  logic [7:0] m_data  = 8'd0;
  logic       m_valid = 1'b0;
  logic [9:0] m_frame = 10'd0;
  logic       m_get   = 1'b0;
  logic       m_ferr  = 1'b0;
  logic       m_ovr   = 1'b0;

  initial begin : monitor
    pend_t f;
    logic  busy;
    forever begin
      @(posedge clk);
      m_get  = 1'b0;
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
      if (!reset) begin
        m_data  = 8'd0;
        m_valid = 1'b0;
        m_frame = 10'd0;
        pend.delete();
      end else begin
        busy = m_valid && !rx_ready_i;
        if (m_valid && rx_ready_i) m_valid = 1'b0;
        if (pend.size() > 0 && pend[0].done == cyc + 1) begin
          f       = pend.pop_front();
          m_get   = 1'b1;
          m_frame = {f.stop, f.data, 1'b0};
          if (!f.stop) m_ferr = 1'b1;
          else if (busy) m_ovr = 1'b1;
          else begin
            m_data  = f.data;
            m_valid = 1'b1;
          end
        end
      end
      #1;
      check_out("mon", m_data, m_valid, m_frame, m_get, m_ferr, m_ovr);
    end
  end

  // Drive one frame starting at the current falling edge; abort_at >= 0 cuts the
  // frame half-way through that bit position (0 = start bit, 1..8 = data bits).
  task automatic send_frame(input logic [7:0] byte_v, input logic stop, input int abort_at);
    logic [9:0] bits;
    bits = {stop, byte_v, 1'b0};
    pend.push_back('{done: cyc + 1 + LAT, data: byte_v, stop: stop});
    for (int i = 0; i < 10; i++) begin
      rx_i = bits[i];
      if (i == abort_at) begin
        repeat (CPB / 2) @(negedge clk);
        rx_i = 1'b1;
        return;
      end
      repeat (CPB) @(negedge clk);
    end
    rx_i = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       ready;
    logic [7:0] e_data;
    logic       e_valid;
    logic [9:0] e_frame;
    logic       e_ferr;
    logic       e_ovr;
  } vec_t;

  vec_t vec[NV];
  bit   rand_done;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int e0;
    int gap;
    logic [7:0] rb;
    logic rs;

    vec[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 10'b1_10100101_0, 1'b0, 1'b0};
    vec[1] = '{8'h3C, 1'b0, 1'b0, 8'hA5, 1'b1, 10'b0_00111100_0, 1'b1, 1'b0};
    vec[2] = '{8'h11, 1'b1, 1'b0, 8'hA5, 1'b1, 10'b1_00010001_0, 1'b0, 1'b1};
    vec[3] = '{8'h22, 1'b1, 1'b1, 8'h22, 1'b1, 10'b1_00100010_0, 1'b0, 1'b0};
    vec[4] = '{8'h3C, 1'b0, 1'b1, 8'h22, 1'b0, 10'b0_00111100_0, 1'b1, 1'b0};
    vec[5] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 10'b1_00000000_0, 1'b0, 1'b0};
    vec[6] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 10'b1_11111111_0, 1'b0, 1'b0};

    repeat (5) @(negedge clk);
    check_out("reset", 8'h00, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      rx_ready_i = vec[i].ready;
      e0 = cyc + 1;
      fork
        send_frame(vec[i].data, vec[i].stop, -1);
        begin
          wait_edge(e0 + LAT);
          check_out($sformatf("vec%0d", i), vec[i].e_data, vec[i].e_valid, vec[i].e_frame,
                    1'b1, vec[i].e_ferr, vec[i].e_ovr);
        end
      join
      repeat (20) @(negedge clk);
    end

    // Byte held without ready, then released by a single ready edge.
    rx_ready_i = 1'b0;
    repeat (4) @(negedge clk);
    send_frame(8'hA5, 1'b1, -1);
    repeat (10) @(negedge clk);
    check("hold.valid", rx_valid_o, 1'b1);
    check("hold.data", rx_data_o, 8'hA5);
    rx_ready_i = 1'b1;
    @(negedge clk);
    check("consume.valid", rx_valid_o, 1'b0);
    rx_ready_i = 1'b0;
    repeat (5) @(negedge clk);

    // Short low glitch must not produce a frame.
    rx_i = 1'b0;
    repeat (4) @(negedge clk);
    rx_i = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch.valid", rx_valid_o, 1'b0);
    check("glitch.frame", frame_o, 10'b1_10100101_0);

    // Back-to-back frames, nothing consumed: second one overruns.
    e0 = cyc + 1;
    fork
      begin
        send_frame(8'h11, 1'b1, -1);
        send_frame(8'h22, 1'b1, -1);
      end
      begin
        wait_edge(e0 + LAT);
        check_out("b2b1", 8'h11, 1'b1, 10'b1_00010001_0, 1'b1, 1'b0, 1'b0);
        wait_edge(e0 + 10 * CPB + LAT);
        check_out("b2b2", 8'h11, 1'b1, 10'b1_00100010_0, 1'b1, 1'b0, 1'b1);
      end
    join
    rx_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    rx_ready_i = 1'b0;
    repeat (20) @(negedge clk);

    // Back-to-back with ready only on the second completion edge: swap, no overrun.
    e0 = cyc + 1;
    fork
      begin
        send_frame(8'h11, 1'b1, -1);
        send_frame(8'h22, 1'b1, -1);
      end
      begin
        wait_edge(e0 + LAT);
        check_out("swap1", 8'h11, 1'b1, 10'b1_00010001_0, 1'b1, 1'b0, 1'b0);
        wait_edge(e0 + 10 * CPB + LAT - 1);
        rx_ready_i = 1'b1;
        wait_edge(e0 + 10 * CPB + LAT);
        check_out("swap2", 8'h22, 1'b1, 10'b1_00100010_0, 1'b1, 1'b0, 1'b0);
        rx_ready_i = 1'b0;
      end
    join
    repeat (20) @(negedge clk);

    // Reset in the middle of data bit 4, then a clean frame.
    send_frame(8'hFF, 1'b1, 5);
    reset = 1'b0;
    #1;
    check_out("midrst", 8'h00, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("postrst.valid", rx_valid_o, 1'b0);
    e0 = cyc + 1;
    fork
      send_frame(8'h5A, 1'b1, -1);
      begin
        wait_edge(e0 + LAT);
        check_out("after_rst", 8'h5A, 1'b1, 10'b1_01011010_0, 1'b1, 1'b0, 1'b0);
      end
    join
    repeat (20) @(negedge clk);

    // Random traffic with random ready; the monitor checks every edge.
    rand_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 24; n++) begin
          rb  = 8'($urandom_range(0, 255));
          rs  = ($urandom_range(0, 3) != 0);
          send_frame(rb, rs, -1);
          gap = rs ? ($urandom_range(0, 2) == 0 ? 0 : $urandom_range(1, 12))
                   : $urandom_range(20, 30);
          repeat (gap) @(negedge clk);
        end
        repeat (30) @(negedge clk);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(negedge clk);
          rx_ready_i = ($urandom_range(0, 2) == 0);
        end
      end
    join
    check("rand.pending", pend.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
